// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, FSM state encoding and tap-index helper for
//               the multi-channel 2D convolution engine (conv2d_mc).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int c_PIX_W  = 8;   // unsigned pixel width
    localparam int c_TAP_W  = 8;   // signed kernel tap width
    localparam int c_PROD_W = 17;  // signed pixel x tap product width

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Flat position of tap (c,ky,kx) in the packed kernel vector.
    function automatic int tap_idx(input int c, input int ky, input int kx, input int kmax);
        return c * kmax * kmax + ky * kmax + kx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac
// Description : Multiply-accumulate datapath. Zero-extended pixel times signed
//               tap, sign-extended into a wrapping ACCW-bit accumulator.
//               Build option CONV_RELU_EN clamps negative results to zero at
//               the output; the accumulator itself is never clamped.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac
    import conv_pkg::*;
#(
    parameter int ACCW = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_PIX_W-1:0]        pixel,
    input  logic signed [c_TAP_W-1:0] tap,
    input  logic                      clr,
    input  logic                      en,
    output logic [ACCW-1:0]           acc_out
);

    logic signed [c_PROD_W-1:0] w_prod;
    logic [ACCW-1:0]            w_prod_ext;
    logic [ACCW-1:0]            r_acc;

    assign w_prod     = c_PROD_W'($signed({1'b0, pixel})) * c_PROD_W'(tap);
    assign w_prod_ext = ACCW'(w_prod);

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

`ifdef CONV_RELU_EN
    assign acc_out = r_acc[ACCW-1] ? '0 : r_acc;
`else
    assign acc_out = r_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/conv2d_mc.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_mc
// Description : Multi-channel valid 2D convolution. CIN byte planes are
//               convolved with a runtime-sized kernel and strides, summed
//               into one output plane of ACCW-bit words. One product per
//               cycle, one write cycle per output. Build option CONV_RELU_EN
//               selects ReLU-clamped output words.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_mc
    import conv_pkg::*;
#(
    parameter int DSIZE = 256,
    parameter int KMAX  = 5,
    parameter int CIN   = 2,
    parameter int ACCW  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_width,
    input  logic [7:0]                    data_height,
    input  logic [3:0]                    stride_x,
    input  logic [3:0]                    stride_y,
    input  logic [3:0]                    kernel_size,
    input  logic [8*CIN*KMAX*KMAX-1:0]    kernel,
    input  logic [$clog2(DSIZE):0]        mi_addr,
    input  logic [1:0]                    mi_ch,
    input  logic [31:0]                   mi_data,
    input  logic                          mi_wr,
    input  logic [$clog2(DSIZE):0]        mo_addr,
    output logic [ACCW-1:0]               mo_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int c_AW  = $clog2(DSIZE) + 1;
    localparam int c_DAW = $clog2(DSIZE);
    localparam int c_CW  = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int c_KW  = 8 * CIN * KMAX * KMAX;
    localparam logic [c_CW-1:0] c_CLAST = c_CW'(CIN - 1);

    logic [2:0]        r_state;
    logic              r_done, r_err;
    logic [7:0]        r_w, r_h;
    logic [3:0]        r_sx, r_sy, r_k;
    logic [c_KW-1:0]   r_kernel;
    logic [c_CW-1:0]   r_c;
    logic [3:0]        r_ky, r_kx;
    logic [7:0]        r_x0, r_y0;
    logic [c_AW-1:0]   r_oidx;

    logic [7:0]        r_imem [CIN][DSIZE];
    logic [ACCW-1:0]   r_omem [DSIZE];

    logic              w_busy, w_cfg_bad, w_row_end, w_col_end;
    logic [3:0]        w_klast;
    logic [9:0]        w_nx, w_ny;
    logic [8:0]        w_row, w_col;
    logic [16:0]       w_paddr;
    logic [7:0]        w_pix;
    logic signed [7:0] w_tap;
    logic [ACCW-1:0]   w_acc;
    logic [c_AW:0]     w_waddr [4];

    assign w_busy = (r_state == ST_LOAD) || (r_state == ST_MAC) || (r_state == ST_WRITE);
    assign busy   = w_busy;
    assign done   = r_done;
    assign err    = r_err;

    assign w_cfg_bad = (kernel_size == 4'd0) || (32'(kernel_size) > KMAX) ||
                       ({4'd0, kernel_size} > data_width) ||
                       ({4'd0, kernel_size} > data_height) ||
                       (stride_x == 4'd0) || (stride_y == 4'd0);

    assign w_klast   = r_k - 4'd1;
    assign w_nx      = {2'b00, r_x0} + {6'd0, r_sx};
    assign w_ny      = {2'b00, r_y0} + {6'd0, r_sy};
    assign w_row_end = (w_nx + {6'd0, r_k}) > {2'b00, r_w};
    assign w_col_end = (w_ny + {6'd0, r_k}) > {2'b00, r_h};

    // Pixel under the current tap; out-of-plane addresses read as zero.
    assign w_row   = {1'b0, r_y0} + {5'd0, r_ky};
    assign w_col   = {1'b0, r_x0} + {5'd0, r_kx};
    assign w_paddr = 17'(w_row) * 17'(r_w) + 17'(w_col);
    assign w_pix   = (32'(w_paddr) < DSIZE) ? r_imem[r_c][w_paddr[c_DAW-1:0]] : 8'd0;
    assign w_tap   = r_kernel[8*tap_idx(int'(r_c), int'(r_ky), int'(r_kx), KMAX) +: 8];

    conv_mac #(.ACCW(ACCW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .pixel   (w_pix),
        .tap     (w_tap),
        .clr     ((r_state == ST_LOAD) || (r_state == ST_WRITE)),
        .en      (r_state == ST_MAC),
        .acc_out (w_acc)
    );

    // Byte addresses of the four lanes of a host write.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_waddr[i] = {1'b0, mi_addr} + (c_AW + 1)'(i);
        end
    end

    // Host write port into the input planes, frozen while a run is active.
    always_ff @(posedge clk) begin
        if (mi_wr && !w_busy && (32'(mi_ch) < CIN)) begin
            for (int i = 0; i < 4; i++) begin
                if (32'(w_waddr[i]) < DSIZE) begin
                    r_imem[mi_ch[c_CW-1:0]][w_waddr[i][c_DAW-1:0]] <= mi_data[8*i +: 8];
                end
            end
        end
    end

    // Result write; output memory has no reset so untouched words persist.
    always_ff @(posedge clk) begin
        if ((r_state == ST_WRITE) && (32'(r_oidx) < DSIZE)) begin
            r_omem[r_oidx[c_DAW-1:0]] <= w_acc;
        end
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mo_data <= '0;
        end else begin
            mo_data <= (32'(mo_addr) < DSIZE) ? r_omem[mo_addr[c_DAW-1:0]] : '0;
        end
    end

    // Control FSM: configuration latch, tap/channel walk and origin stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_w      <= '0;
            r_h      <= '0;
            r_sx     <= '0;
            r_sy     <= '0;
            r_k      <= '0;
            r_kernel <= '0;
            r_c      <= '0;
            r_ky     <= '0;
            r_kx     <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_oidx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_w      <= data_width;
                    r_h      <= data_height;
                    r_sx     <= stride_x;
                    r_sy     <= stride_y;
                    r_k      <= kernel_size;
                    r_kernel <= kernel;
                    r_c      <= '0;
                    r_ky     <= '0;
                    r_kx     <= '0;
                    r_x0     <= '0;
                    r_y0     <= '0;
                    r_oidx   <= '0;
                    if (w_cfg_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_kx != w_klast) begin
                        r_kx <= r_kx + 4'd1;
                    end else begin
                        r_kx <= 4'd0;
                        if (r_ky != w_klast) begin
                            r_ky <= r_ky + 4'd1;
                        end else begin
                            r_ky <= 4'd0;
                            if (r_c != c_CLAST) begin
                                r_c <= r_c + c_CW'(1);
                            end else begin
                                r_c     <= '0;
                                r_state <= ST_WRITE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    r_oidx <= r_oidx + c_AW'(1);
                    if (!w_row_end) begin
                        r_x0    <= w_nx[7:0];
                        r_state <= ST_MAC;
                    end else begin
                        r_x0 <= 8'd0;
                        if (w_col_end) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_y0    <= w_ny[7:0];
                            r_state <= ST_MAC;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/conv2d_mc.md
# conv2d_mc

Multi-channel, parametrised successor to the single-channel convolution engine. It computes a valid (no-padding) 2D convolution over CIN input planes, summed into one output plane. Kernel size and stride are runtime-selectable. It keeps the same byte-packed input write port and word output read port, so existing benches and the host-side loader carry over with one added channel-select field.

## Interface
- DSIZE, 256: bytes per input plane; also output memory depth in words
- KMAX, 5: largest supported kernel side
- CIN, 2: input channel count, 1..4
- ACCW, 32: accumulator and output word width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- data_width, data_height  in  8 each  plane dimensions in pixels
- stride_x, stride_y  in  4 each  step in pixels, 1..15
- kernel_size  in  4  kernel side K, 1..KMAX
- kernel  in  8*CIN*KMAX*KMAX  signed 8-bit taps. Tap (c,ky,kx) sits at bits [8*(c*KMAX*KMAX+ky*KMAX+kx) +: 8]. Unused taps are ignored.
- mi_addr  in  $clog2(DSIZE)+1  byte address, 4-aligned
- mi_ch  in  2  target plane
- mi_data  in  32  four pixels, little-endian (byte 0 = mi_addr)
- mi_wr  in  1  write strobe
- mo_addr  in  $clog2(DSIZE)+1  output word index
- mo_data  out  ACCW  output word, registered
- start  in  1  one-cycle launch pulse
- busy, done, err  out  1 each  status

## Operation
- Pixels are unsigned 8-bit and zero-extended. Taps are signed. Each 17-bit signed product is sign-extended to ACCW. Accumulation wraps modulo 2^ACCW.
- Output origin positions are x = 0, S, 2S, … while x+K ≤ W, and likewise for y. Output (oy,ox) is written at word oy*OW+ox, row-major.
- Each output sums over c, then ky, then kx, with c outermost. Each output is the sum over all channels.
- FSM states:
  - IDLE: start while in IDLE moves to LOAD.
  - LOAD: latches all configuration inputs and kernel. If K=0, K>KMAX, K>W, K>H, or a stride is 0, it sets err and moves to DONE. Otherwise it moves to MAC.
  - MAC: one product per cycle.
  - WRITE: writes the accumulator (clamped under RELU, see Configuration) and clears it. Then MAC if outputs remain, else DONE.
  - DONE: asserts done and returns to IDLE.
- Status flags:
  - done stays high in IDLE until the next accepted start or rst.
  - err clears on the next accepted start.
  - busy is high in LOAD, MAC and WRITE.
- start during busy is ignored.
- mi_wr during busy is ignored, so input memory is frozen while a run is in progress.
- Output words not written by a run keep their previous contents. Output memory is not cleared by reset.
- Config inputs may change after LOAD without effect on the current run.

## Timing
- Reset values:
  - busy, done and err = 0; state = IDLE; accumulator = 0.
  - mo_data = 0 until the first read clock after reset.
- start is sampled at edge t. LOAD occupies cycle t+1 and busy is high from t+1.
- Each output takes CIN*K*K MAC cycles plus 1 WRITE cycle. A run of N outputs has busy high for 1 + N*(CIN*K*K+1) cycles.
- done rises on the cycle after busy falls. An err run has busy high for 1 cycle.
- mo_data reflects mo_addr sampled at the previous edge, giving 1-cycle read latency. Reads during busy are permitted, but a word being written returns its old value.
- mi_wr takes effect at the edge it is sampled on.
- rst mid-run aborts immediately to IDLE with done=0. Partially written output is left as-is.

## Configuration
- CONV_RELU_EN:
  - Defined: WRITE stores 0 for any negative accumulator.
  - Undefined: WRITE stores the raw two's-complement value.
- Cycle counts are identical in both builds.

## Structure
- Package conv_pkg holds the FSM state enum, the pixel width (8), tap width (8) and product width (17), and the tap-index helper function.
- Sub-module conv_mac handles the multiply-accumulate: pixel, tap, clear and enable in; ACCW accumulator out, with the RELU clamp applied at its output.
- The top level holds the input planes (CIN×DSIZE bytes), the output memory, address counters and the FSM.

## Test plan
- CIN=2, 8×8 plane 0 = ramp 0..63, plane 1 = 0, K=3, stride 1, ch0 rows {1,0,-1}, ch1 taps 0 -> 36 words, all 0xFFFFFFFA (0 with CONV_RELU_EN). busy high for 685 cycles.
- Same data, stride_x = stride_y = 2 -> 9 outputs at x,y ∈ {0,2,4}, words 0..8 = 0xFFFFFFFA. Word 9 is untouched.
- Both planes all 1, K=2, all taps 1, stride 1 -> 49 words, each 8. Proves the channel summation.
- kernel_size = 0, then separately kernel_size = 9 on an 8×8 plane -> err=1, done=1, busy high 1 cycle, no output writes.
- rst asserted 20 cycles into a run -> busy, done and err = 0 immediately. A following start completes the run correctly.
- Second start and mi_wr pulses during busy -> ignored. Output matches the scenario-1 values and run length is unchanged.
